exhaustive_vector_driver: RTL and testbench
===========================================

Name: exhaustive_vector_driver

Overview:
- On-chip counterpart of the exhaustive-stimulus benches: drives every input pattern of a small combinational/sequential unit under test (UUT), samples its single-bit output and streams back {pattern, response} records.
- Also accumulates the full truth-table response vector.
- Sits beside the UUT in trojan-detection harnesses. A capture agent consumes records through a valid/ready handshake, replacing file-based dumps.

Parameters:
- N_IN, 4, number of UUT input bits; patterns 0 .. 2^N_IN-1.
- SETTLE, 1, extra cycles (0..15) between applying a pattern and sampling the UUT output.

Ports:
- CK  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- busy  output  1  high from the cycle after an accepted start until DONE is left.
- done  output  1  one-cycle pulse when the sweep completes.
- N_out  output  N_IN  pattern driven to the UUT; N_out[0] is the MSB, pattern bit N_IN-1.
- uut_out  input  1  UUT single-bit response.
- rec_valid  output  1  record available.
- rec_ready  input  1  consumer accepts the record.
- rec_pattern  output  N_IN  pattern of the current record.
- rec_resp  output  1  sampled response of the current record.
- resp_vec  output  2^N_IN  truth table; bit p is the response to pattern p.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - N_out, rec_pattern, rec_resp, resp_vec, rec_valid, busy, done all 0.
  - Settle counter is 0.
  - Reset asserted mid-sweep aborts immediately. No done pulse; resp_vec is cleared.
- States: IDLE, WAIT, EMIT, DONE.
- IDLE:
  - start=1 → WAIT, with pattern=0, N_out=0, cnt=SETTLE, busy=1 and resp_vec cleared (all on the same edge).
  - resp_vec otherwise holds the previous sweep's result.
- WAIT:
  - cnt≠0 → cnt decrements.
  - cnt==0 → that edge captures uut_out into rec_resp and resp_vec[pattern], loads rec_pattern=pattern, sets rec_valid=1, and moves to EMIT.
- EMIT:
  - rec_valid, rec_pattern and rec_resp stay stable until rec_valid&rec_ready.
  - On handshake, rec_valid=0 on the same edge.
  - If pattern==2^N_IN-1 → DONE.
  - Otherwise pattern+1 → N_out updates, cnt=SETTLE, → WAIT.
- DONE: done=1 for exactly one cycle, busy=0 on the following edge, → IDLE. N_out holds the last pattern.
- Per-pattern latency with rec_ready tied high: 2+SETTLE cycles, counted from N_out change to next N_out change.
- Full sweep from the start edge to the done pulse: 2^N_IN*(2+SETTLE) cycles.
- start while busy or in DONE: ignored, with no effect on the sweep.
- rec_ready is ignored outside EMIT.
- Pattern counter is N_IN+1 bits wide internally. The terminal compare is explicit, so there is no wrap-around to 0 within a sweep.
- Back-pressure: the sweep stalls indefinitely in EMIT. N_out holds and the UUT is not re-sampled.

Test Plan:
- Reset and idle: reset low for 5 ns, then high, CK at 20 ns period, start=0 → all outputs 0 for 10 cycles, busy=0.
- Full sweep, identity-LSB UUT (uut_out=N_out[3]), SETTLE=1, rec_ready=1, one-cycle start pulse:
  - 16 records, patterns 0..15, in order.
  - rec_resp alternates 0,1.
  - resp_vec=16'hAAAA.
  - done pulses exactly 48 cycles after the start edge; busy then drops.
- Back-pressure: AND-of-all UUT, rec_ready low for 7 cycles at pattern 5 → rec_valid, rec_pattern=5 and N_out stay stable. Sweep resumes after ready rises; resp_vec=16'h8000.
- SETTLE=0 with a registered UUT (output = previous N_out[3]):
  - Responses reflect the prior pattern; resp_vec=16'h5554.
  - Confirms the sample-timing edge.
- Mid-sweep reset: assert reset at pattern 9 → all outputs 0 asynchronously, no done pulse. A new start sweeps from pattern 0 again.
- start re-asserted while busy at pattern 3 → no restart, record order unchanged, a single done pulse.

Source files
------------

// File: rtl/exhaustive_vector_driver_if.sv
// Stimulus/record bus between the exhaustive vector driver, the unit under test and the capture agent.
// The master modport is the driver side.
interface exhaustive_vector_driver_if #(
    parameter int unsigned N_IN = 4
);
    localparam int unsigned NPAT = 1 << N_IN;

    logic              start;
    logic              busy;
    logic              done;
    logic [N_IN-1:0]   N_out;
    logic              uut_out;
    logic              rec_valid;
    logic              rec_ready;
    logic [N_IN-1:0]   rec_pattern;
    logic              rec_resp;
    logic [NPAT-1:0]   resp_vec;

    modport master (
        input  start, uut_out, rec_ready,
        output busy, done, N_out, rec_valid, rec_pattern, rec_resp, resp_vec
    );

    modport slave (
        output start, uut_out, rec_ready,
        input  busy, done, N_out, rec_valid, rec_pattern, rec_resp, resp_vec
    );
endinterface

// File: rtl/exhaustive_vector_driver.sv
// Sweeps every input pattern of a small UUT, samples its one-bit response after a settle
// delay and streams {pattern, response} records while building the full truth table.
module exhaustive_vector_driver #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                        CK,
    input  logic                        reset,
    exhaustive_vector_driver_if.master  bus
);
    localparam int unsigned PW   = N_IN + 1;
    localparam int unsigned NPAT = 1 << N_IN;
    localparam logic [PW-1:0] LAST_PAT  = PW'(NPAT - 1);
    localparam logic [3:0]    SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   pattern;
    logic [3:0]      cnt;
    logic [N_IN-1:0] n_out_q;
    logic [N_IN-1:0] rec_pattern_q;
    logic            rec_resp_q;
    logic            rec_valid_q;
    logic [NPAT-1:0] resp_vec_q;
    logic            busy_q;
    logic            done_q;

    // UUT pins are numbered MSB-first: pin 0 carries pattern bit N_IN-1.
    function automatic logic [N_IN-1:0] msb_first(input logic [N_IN-1:0] p);
        logic [N_IN-1:0] r;
        for (int i = 0; i < int'(N_IN); i++) begin
            r[i] = p[N_IN-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pattern       <= '0;
            cnt           <= '0;
            n_out_q       <= '0;
            rec_pattern_q <= '0;
            rec_resp_q    <= 1'b0;
            rec_valid_q   <= 1'b0;
            resp_vec_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state      <= WAIT;
                        pattern    <= '0;
                        n_out_q    <= '0;
                        cnt        <= SETTLE_CNT;
                        busy_q     <= 1'b1;
                        resp_vec_q <= '0;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rec_resp_q                       <= bus.uut_out;
                        resp_vec_q[pattern[N_IN-1:0]]    <= bus.uut_out;
                        rec_pattern_q                    <= pattern[N_IN-1:0];
                        rec_valid_q                      <= 1'b1;
                        state                            <= EMIT;
                    end
                end
                EMIT: begin
                    // Record is held until the consumer takes it; the UUT is not re-sampled.
                    if (bus.rec_ready) begin
                        rec_valid_q <= 1'b0;
                        if (pattern == LAST_PAT) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            pattern <= pattern + PW'(1);
                            n_out_q <= msb_first(pattern[N_IN-1:0] + N_IN'(1));
                            cnt     <= SETTLE_CNT;
                            state   <= WAIT;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.N_out       = n_out_q;
    assign bus.rec_valid   = rec_valid_q;
    assign bus.rec_pattern = rec_pattern_q;
    assign bus.rec_resp    = rec_resp_q;
    assign bus.resp_vec    = resp_vec_q;
endmodule

// File: tb/tb_exhaustive_vector_driver.sv
// Bench for exhaustive_vector_driver: two instances (SETTLE=1 with selectable UUT, SETTLE=0 with
// a registered UUT), records checked against a queue of expected {pattern, response} pairs.
module tb_exhaustive_vector_driver;
    localparam int unsigned N_IN = 4;

    typedef struct packed {
        logic [3:0] pat;
        logic       resp;
    } rec_t;

    logic CK = 1'b0;
    logic reset;
    logic start_a, start_b, ready_a;
    logic uut_mode;
    logic reg_uut;

    int   n_checks = 0;
    int   n_errors = 0;
    int   a_done_cnt = 0;
    int   b_done_cnt = 0;
    rec_t qa[$];
    rec_t qb[$];
    rec_t ea, eb;

    always #10 CK = ~CK;

    exhaustive_vector_driver_if #(.N_IN(N_IN)) bus_a ();
    exhaustive_vector_driver_if #(.N_IN(N_IN)) bus_b ();

    // UUT A: mode 0 returns the pattern LSB (pin 3), mode 1 the AND of all pins.
    assign bus_a.uut_out   = uut_mode ? (&bus_a.N_out) : bus_a.N_out[3];
    assign bus_a.start     = start_a;
    assign bus_a.rec_ready = ready_a;

    always @(posedge CK or negedge reset) begin
        if (!reset) reg_uut <= 1'b0;
        else        reg_uut <= bus_b.N_out[3];
    end
    assign bus_b.uut_out   = reg_uut;
    assign bus_b.start     = start_b;
    assign bus_b.rec_ready = 1'b1;

    exhaustive_vector_driver #(.N_IN(N_IN), .SETTLE(1)) dut_a (
        .CK    (CK),
        .reset (reset),
        .bus   (bus_a)
    );

    exhaustive_vector_driver #(.N_IN(N_IN), .SETTLE(0)) dut_b (
        .CK    (CK),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = v[3-i];
        return r;
    endfunction

    task automatic push_a(input bit and_mode);
        rec_t r;
        for (int p = 0; p < 16; p++) begin
            r.pat  = 4'(p);
            r.resp = and_mode ? (p == 15) : p[0];
            qa.push_back(r);
        end
    endtask

    task automatic push_b();
        rec_t r;
        for (int p = 0; p < 16; p++) begin
            r.pat  = 4'(p);
            r.resp = (p == 0) ? 1'b0 : ((p - 1) % 2 == 1);
            qb.push_back(r);
        end
    endtask

    // Scoreboard: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge CK) begin
        if (reset && bus_a.rec_valid && bus_a.rec_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_record", 32'(bus_a.rec_pattern), 32'hFFFF);
            end else begin
                ea = qa.pop_front();
                check("a_rec_pattern", 32'(bus_a.rec_pattern), 32'(ea.pat));
                check("a_rec_resp", 32'(bus_a.rec_resp), 32'(ea.resp));
            end
        end
        if (bus_a.done) a_done_cnt++;
    end

    always @(negedge CK) begin
        if (reset && bus_b.rec_valid && bus_b.rec_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_record", 32'(bus_b.rec_pattern), 32'hFFFF);
            end else begin
                eb = qb.pop_front();
                check("b_rec_pattern", 32'(bus_b.rec_pattern), 32'(eb.pat));
                check("b_rec_resp", 32'(bus_b.rec_resp), 32'(eb.resp));
            end
        end
        if (bus_b.done) b_done_cnt++;
    end

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int cyc);
        logic d;
        cyc = 0;
        do begin
            step();
            cyc++;
            d = sel ? bus_b.done : bus_a.done;
        end while (!d && cyc < 400);
        if (!d) check("done_timeout", 32'(cyc), 32'(0));
    endtask

    task automatic wait_pat_a(input int p, input bit need_valid);
        int n = 0;
        while (!(rev4(bus_a.N_out) == 4'(p) && (!need_valid || bus_a.rec_valid)) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) check("pattern_timeout", 32'(p), 32'hFFFF);
    endtask

    task automatic check_a_cleared(input string tag);
        check(tag, 32'({bus_a.busy, bus_a.done, bus_a.N_out, bus_a.rec_valid,
                        bus_a.rec_pattern, bus_a.rec_resp, bus_a.resp_vec}), 32'(0));
    endtask

    initial begin
        int cyc;
        int d0;
        reset    = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        ready_a  = 1'b1;
        uut_mode = 1'b0;
        #5 reset = 1'b1;

        // Reset and idle
        repeat (10) begin
            @(negedge CK);
            check_a_cleared("idle_a_outputs");
            check("idle_b_busy", 32'(bus_b.busy), 32'(0));
        end
        step();

        // Full sweep, LSB UUT
        push_a(1'b0);
        pulse_start(1'b0);
        check("a_busy_after_start", 32'(bus_a.busy), 32'(1));
        wait_done(1'b0, cyc);
        check("lsb_sweep_cycles", 32'(cyc), 32'(48));
        check("lsb_resp_vec", 32'(bus_a.resp_vec), 32'hAAAA);
        step();
        check("lsb_busy_drop", 32'(bus_a.busy), 32'(0));
        check("lsb_done_pulse", 32'(bus_a.done), 32'(0));
        check("lsb_queue_empty", 32'(qa.size()), 32'(0));

        // Back-pressure at pattern 5, AND UUT
        uut_mode = 1'b1;
        push_a(1'b1);
        pulse_start(1'b0);
        wait_pat_a(5, 1'b0);
        ready_a = 1'b0;
        wait_pat_a(5, 1'b1);
        repeat (7) begin
            step();
            check("bp_valid", 32'(bus_a.rec_valid), 32'(1));
            check("bp_pattern", 32'(bus_a.rec_pattern), 32'(5));
            check("bp_n_out", 32'(bus_a.N_out), 32'(rev4(4'd5)));
        end
        ready_a = 1'b1;
        wait_done(1'b0, cyc);
        check("and_resp_vec", 32'(bus_a.resp_vec), 32'h8000);
        check("and_queue_empty", 32'(qa.size()), 32'(0));
        step();

        // SETTLE=0 with a registered UUT
        push_b();
        pulse_start(1'b1);
        wait_done(1'b1, cyc);
        check("reg_sweep_cycles", 32'(cyc), 32'(32));
        check("reg_resp_vec", 32'(bus_b.resp_vec), 32'h5554);
        step();
        check("reg_queue_empty", 32'(qb.size()), 32'(0));
        check("reg_done_count", 32'(b_done_cnt), 32'(1));

        // Mid-sweep reset at pattern 9
        uut_mode = 1'b0;
        push_a(1'b0);
        pulse_start(1'b0);
        wait_pat_a(9, 1'b1);
        d0 = a_done_cnt;
        #4 reset = 1'b0;
        #1;
        check_a_cleared("abort_outputs");
        qa.delete();
        repeat (3) @(posedge CK);
        @(negedge CK);
        reset = 1'b1;
        step();
        check_a_cleared("abort_after_release");
        check("abort_no_done", 32'(a_done_cnt), 32'(d0));
        push_a(1'b0);
        pulse_start(1'b0);
        wait_done(1'b0, cyc);
        check("restart_sweep_cycles", 32'(cyc), 32'(48));
        check("restart_resp_vec", 32'(bus_a.resp_vec), 32'hAAAA);
        step();
        check("restart_queue_empty", 32'(qa.size()), 32'(0));

        // start re-asserted while busy at pattern 3
        d0 = a_done_cnt;
        push_a(1'b0);
        pulse_start(1'b0);
        wait_pat_a(3, 1'b0);
        pulse_start(1'b0);
        check("busy_start_pattern", 32'(rev4(bus_a.N_out)), 32'(3));
        wait_done(1'b0, cyc);
        check("busy_start_resp_vec", 32'(bus_a.resp_vec), 32'hAAAA);
        repeat (3) begin
            step();
            check("busy_start_idle", 32'(bus_a.busy), 32'(0));
        end
        check("busy_start_done_count", 32'(a_done_cnt), 32'(d0 + 1));
        check("busy_start_queue_empty", 32'(qa.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
